// File: rtl/rhythm_pkg.sv
// Shared sprite geometry and flash-state type for the rhythm-game sprite readers.
package rhythm_pkg;

  localparam int unsigned SPRITE_W    = 40;
  localparam int unsigned SPRITE_H    = 40;
  localparam int unsigned SPRITE_BITS = SPRITE_W * SPRITE_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    HELD  = 2'd2
  } flash_state_t;

endpackage

// File: rtl/arrow_sprite_reader_if.sv
// Scan/dropper inputs and pixel/flash/count outputs of the arrow sprite reader.
interface arrow_sprite_reader_if #(
  parameter int unsigned BITS = rhythm_pkg::SPRITE_BITS
);

  logic            frame_clk;
  logic [9:0]      DrawX;
  logic [9:0]      DrawY;
  logic [9:0]      dropX;
  logic [9:0]      dropY;
  logic [BITS-1:0] arrow;
  logic            score;
  logic            pixel_on;
  logic            flash_on;
  logic [7:0]      hit_count;

  modport master (
    output frame_clk, DrawX, DrawY, dropX, dropY, arrow, score,
    input  pixel_on, flash_on, hit_count
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, dropX, dropY, arrow, score,
    output pixel_on, flash_on, hit_count
  );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for a level signal synchronous to Clk; PREV_INIT sets
// whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic PREV_INIT = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) prev <= PREV_INIT;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/arrow_sprite_reader.sv
// Two-stage sprite pixel lookup with frame-latched position/bitmap, plus a
// hit counter and hit-flash FSM driven by the dropper score flag.
module arrow_sprite_reader #(
  parameter int unsigned SPRITE_W     = rhythm_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H     = rhythm_pkg::SPRITE_H,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input logic                  Clk,
  input logic                  Reset,
  arrow_sprite_reader_if.slave bus
);

  import rhythm_pkg::*;

  localparam int unsigned BITS   = SPRITE_W * SPRITE_H;
  localparam int unsigned IDX_W  = $clog2(BITS);
  localparam int unsigned FCNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLASH_FRAMES);

  logic frame_rise;
  logic score_rise;

  rise_detect #(.PREV_INIT(1'b1)) u_frame_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .sig   (bus.frame_clk),
    .rise  (frame_rise)
  );

  rise_detect #(.PREV_INIT(1'b0)) u_score_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .sig   (bus.score),
    .rise  (score_rise)
  );

  // Position and bitmap only change at frame starts so a sprite never tears mid-frame.
  logic [9:0]      sh_x;
  logic [9:0]      sh_y;
  logic [BITS-1:0] sh_arrow;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_arrow <= '0;
    end else if (frame_rise) begin
      sh_x     <= bus.dropX;
      sh_y     <= bus.dropY;
      sh_arrow <= bus.arrow;
    end
  end

  // Box limits are formed in 11 bits so a sprite parked near 1023 cannot wrap to 0.
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_box_c;

  always_comb begin
    x_end    = {1'b0, sh_x} + 11'(SPRITE_W);
    y_end    = {1'b0, sh_y} + 11'(SPRITE_H);
    in_box_c = (bus.DrawX >= sh_x) && ({1'b0, bus.DrawX} < x_end) &&
               (bus.DrawY >= sh_y) && ({1'b0, bus.DrawY} < y_end);
  end

  logic       in_box_q;
  logic [5:0] col_q;
  logic [5:0] row_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_box_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      in_box_q <= in_box_c;
      col_q    <= 6'(bus.DrawX - sh_x);
      row_q    <= 6'(bus.DrawY - sh_y);
    end
  end

  flash_state_t      fstate;
  logic [FCNT_W-1:0] fcnt;
  logic [7:0]        hit_cnt;
  logic              pixel_q;
  logic              flash_q;
  logic [IDX_W-1:0]  idx;

  // Outside the box the bitmap index is parked at 0 so it never runs past the array.
  always_comb begin
    idx = '0;
    if (in_box_q) idx = IDX_W'(row_q * SPRITE_W + col_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_q <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      pixel_q <= in_box_q && sh_arrow[idx];
      flash_q <= in_box_q && (fstate == FLASH);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_cnt <= '0;
      fstate  <= IDLE;
      fcnt    <= '0;
    end else begin
      if (score_rise && (hit_cnt != '1)) hit_cnt <= hit_cnt + 8'd1;
      case (fstate)
        IDLE: begin
          if (score_rise) begin
            fstate <= FLASH;
            fcnt   <= FCNT_LOAD;
          end
        end
        FLASH: begin
          // A fresh hit restarts the flash even on a frame edge.
          if (score_rise) begin
            fcnt <= FCNT_LOAD;
          end else if (frame_rise) begin
            if (fcnt <= FCNT_W'(1)) begin
              fcnt   <= '0;
              fstate <= bus.score ? HELD : IDLE;
            end else begin
              fcnt <= fcnt - FCNT_W'(1);
            end
          end
        end
        HELD: begin
          if (!bus.score) fstate <= IDLE;
        end
        default: begin
          fstate <= IDLE;
          fcnt   <= '0;
        end
      endcase
    end
  end

  assign bus.pixel_on  = pixel_q;
  assign bus.flash_on  = flash_q;
  assign bus.hit_count = hit_cnt;

endmodule

// File: tb/tb_arrow_sprite_reader.sv
// Scoreboard bench for arrow_sprite_reader: probe expectations come from a
// bench-side shadow model and are checked two cycles after the probe is driven.
module tb_arrow_sprite_reader;

  import rhythm_pkg::*;

  localparam int W = 40;
  localparam int H = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arrow_sprite_reader_if bus ();

  arrow_sprite_reader #(
    .SPRITE_W     (W),
    .SPRITE_H     (H),
    .FLASH_FRAMES (8)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         m_sx;
  int         m_sy;
  logic [W*H-1:0] m_arrow;
  bit         m_flash;

  typedef struct {
    int due;
    bit pix;
    bit fl;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check($sformatf("pixel(%0d,%0d)", e.x, e.y), 32'(bus.pixel_on), 32'(e.pix));
      check($sformatf("flash(%0d,%0d)", e.x, e.y), 32'(bus.flash_on), 32'(e.fl));
    end
  end

  function automatic bit in_box_m(input int x, input int y);
    return (x >= m_sx) && (x < m_sx + W) && (y >= m_sy) && (y < m_sy + H);
  endfunction

  function automatic bit pix_m(input int x, input int y);
    if (!in_box_m(x, y)) return 1'b0;
    return m_arrow[(y - m_sy) * W + (x - m_sx)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y);
    exp_t e;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    e.due = cyc + 2;
    e.pix = pix_m(x, y);
    e.fl  = in_box_m(x, y) && m_flash;
    e.x   = x;
    e.y   = y;
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic frame_pulse();
    bus.frame_clk = 1'b1;
    m_sx    = int'(bus.dropX);
    m_sy    = int'(bus.dropY);
    m_arrow = bus.arrow;
    tick();
    bus.frame_clk = 1'b0;
    tick();
  endtask

  task automatic score_pulse();
    bus.score = 1'b1;
    tick();
    bus.score = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.frame_clk = 1'b0;
    bus.DrawX     = '0;
    bus.DrawY     = '0;
    bus.dropX     = '0;
    bus.dropY     = '0;
    bus.arrow     = '0;
    bus.score     = 1'b0;
    m_sx = 0; m_sy = 0; m_arrow = '0; m_flash = 1'b0;

    #12;
    check("rst_pixel", 32'(bus.pixel_on), 32'd0);
    check("rst_flash", 32'(bus.flash_on), 32'd0);
    check("rst_hits", 32'(bus.hit_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Sprite hit, corner and random probes around a box at (100,100).
    bus.dropX = 10'd100;
    bus.dropY = 10'd100;
    for (int i = 0; i < 60; i++) bus.arrow[$urandom_range(0, W*H-1)] = 1'b1;
    bus.arrow[418]  = 1'b1;
    bus.arrow[1599] = 1'b1;
    frame_pulse();
    probe(118, 110);
    probe(99, 110);
    probe(139, 139);
    probe(140, 139);
    for (int i = 0; i < 20; i++) probe($urandom_range(90, 150), $urandom_range(90, 150));
    drain();

    // Sprite near the right edge of the coordinate space must not wrap.
    bus.dropX = 10'd1000;
    frame_pulse();
    probe(5, 110);
    probe(1018, 110);
    drain();

    // Position changes only take effect at a frame edge.
    bus.dropX = 10'd100;
    frame_pulse();
    bus.dropY = 10'd200;
    probe(118, 110);
    probe(118, 210);
    drain();
    frame_pulse();
    probe(118, 110);
    probe(118, 210);
    drain();

    // First hit: flash lasts 8 frame edges, then HELD while score stays high.
    bus.score = 1'b1;
    tick();
    check("hit_first", 32'(bus.hit_count), 32'd1);
    m_flash = 1'b1;
    probe(118, 210);
    drain();
    repeat (7) frame_pulse();
    probe(118, 210);
    drain();
    frame_pulse();
    m_flash = 1'b0;
    probe(118, 210);
    drain();
    check("hit_held", 32'(bus.hit_count), 32'd1);
    check("fsm_held", 32'(dut.fstate), 32'(HELD));
    bus.score = 1'b0;
    tick();
    check("fsm_idle", 32'(dut.fstate), 32'(IDLE));

    // Score rise and frame edge together: both shadow load and count update.
    bus.dropX = 10'd300;
    bus.score = 1'b1;
    frame_pulse();
    bus.score = 1'b0;
    m_flash = 1'b1;
    check("hit_second", 32'(bus.hit_count), 32'd2);
    probe(318, 210);
    probe(118, 210);
    drain();

    // A hit coinciding with the last frame edge reloads instead of ending the flash.
    repeat (7) frame_pulse();
    bus.score = 1'b1;
    frame_pulse();
    bus.score = 1'b0;
    repeat (7) frame_pulse();
    probe(318, 210);
    drain();
    frame_pulse();
    m_flash = 1'b0;
    probe(318, 210);
    drain();
    check("hit_third", 32'(bus.hit_count), 32'd3);
    check("fsm_idle2", 32'(dut.fstate), 32'(IDLE));

    // Saturation.
    repeat (251) score_pulse();
    check("hit_254", 32'(bus.hit_count), 32'd254);
    repeat (9) score_pulse();
    check("hit_sat", 32'(bus.hit_count), 32'd255);
    m_flash = 1'b1;

    // Asynchronous reset in the middle of a flash.
    probe(318, 210);
    drain();
    tick();
    check("pre_rst_pixel", 32'(bus.pixel_on), 32'(pix_m(318, 210)));
    check("pre_rst_flash", 32'(bus.flash_on), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_pixel", 32'(bus.pixel_on), 32'd0);
    check("arst_flash", 32'(bus.flash_on), 32'd0);
    check("arst_hits", 32'(bus.hit_count), 32'd0);
    check("arst_fsm", 32'(dut.fstate), 32'(IDLE));
    m_sx = 0; m_sy = 0; m_arrow = '0; m_flash = 1'b0;

    // frame_clk already high at release must not count as a frame edge.
    bus.dropX     = '0;
    bus.dropY     = '0;
    bus.arrow[0]  = 1'b1;
    bus.frame_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    probe(0, 0);
    drain();
    bus.frame_clk = 1'b0;
    tick();
    frame_pulse();
    probe(0, 0);
    drain();
    check("post_rst_hits", 32'(bus.hit_count), 32'd0);
    score_pulse();
    check("post_rst_hit1", 32'(bus.hit_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
